// File: rtl/ext_mem_port_pkg.sv
// Shared types for the external memory port: dataflow tokens, widths, FSM states.
`default_nettype none

package pkg_en;

  localparam int WIDTH_DATA   = 16;
  localparam int WIDTH_EXADDR = 8;
  localparam int WIDTH_INDEX  = 6;

  // Forward token: valid, first-of-stream, reserved flags, index, payload.
  typedef struct packed {
    logic                   v;
    logic                   a;
    logic                   r;
    logic                   c;
    logic [WIDTH_INDEX-1:0] i;
    logic [WIDTH_DATA-1:0]  d;
  } FTk_t;

  // Backward token: n = not-ready (backpressure), t = spare flag.
  typedef struct packed {
    logic n;
    logic t;
  } BTk_t;

  typedef struct packed {
    logic                   a;
    logic [WIDTH_INDEX-1:0] i;
    logic [WIDTH_DATA-1:0]  d;
  } rbuf_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PAD  = 2'd1,
    ST_BOOT = 2'd2,
    ST_RUN  = 2'd3
  } port_state_t;

endpackage

`default_nettype wire

// File: rtl/ext_mem_port_if.sv
// Bundle of load/store/BRAM signals between the array and the external memory port.
`default_nettype none

interface ext_mem_port_if;
  import pkg_en::*;

  logic                    I_Boot;
  logic                    I_Ld_Req;
  logic [WIDTH_EXADDR-1:0] I_Ld_Addr;
  logic                    O_Ld_Rdy;
  FTk_t                    O_Ld_FTk;
  BTk_t                    I_Ld_BTk;
  logic                    I_St_Req;
  logic [WIDTH_EXADDR-1:0] I_St_Addr;
  FTk_t                    I_St_FTk;
  BTk_t                    O_St_BTk;
  logic                    O_Mem_En;
  logic                    O_Mem_We;
  logic [WIDTH_EXADDR-1:0] O_Mem_Addr;
  logic [WIDTH_DATA-1:0]   O_Mem_WData;
  logic [WIDTH_DATA-1:0]   I_Mem_RData;

  modport slave (
    input  I_Boot, I_Ld_Req, I_Ld_Addr, I_Ld_BTk, I_St_Req, I_St_Addr, I_St_FTk, I_Mem_RData,
    output O_Ld_Rdy, O_Ld_FTk, O_St_BTk, O_Mem_En, O_Mem_We, O_Mem_Addr, O_Mem_WData
  );

  modport master (
    output I_Boot, I_Ld_Req, I_Ld_Addr, I_Ld_BTk, I_St_Req, I_St_Addr, I_St_FTk, I_Mem_RData,
    input  O_Ld_Rdy, O_Ld_FTk, O_St_BTk, O_Mem_En, O_Mem_We, O_Mem_Addr, O_Mem_WData
  );

endinterface

`default_nettype wire

// File: rtl/ext_mem_port_rbuf.sv
// Two-entry read buffer; head is presented combinationally from the read pointer.
`default_nettype none

module ext_mem_rbuf
  import pkg_en::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  rbuf_entry_t push_data,
  input  logic        pop,
  output rbuf_entry_t head,
  output logic        full,
  output logic        empty,
  output logic [1:0]  count
);

  rbuf_entry_t mem_q [2];
  rbuf_entry_t mem_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic        do_push, do_pop;

  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ext_mem_port.sv
// External memory port: boot sequencer, credit-gated BRAM loads, and stores, feeding
// a token stream through a two-entry read buffer.
`default_nettype none

module ext_mem_port
  import pkg_en::*;
#(
  parameter int BOOT_PAD  = 3,
  parameter int BOOT_LEN  = 5,
  parameter int BOOT_BASE = 0
) (
  input  logic           clock,
  input  logic           reset,
  ext_mem_port_if.slave  bus
);

  localparam int CNT_W = 16;

  port_state_t             state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    rd_pend_q, rd_pend_d;
  logic [WIDTH_INDEX-1:0]  rd_idx_q, rd_idx_d;

  logic                    credit;
  logic                    pad_push;
  logic                    rd_issue;
  logic [WIDTH_EXADDR-1:0] rd_addr;
  logic                    ld_rdy;
  logic                    store_go;
  logic                    st_nack;

  rbuf_entry_t             push_entry;
  rbuf_entry_t             rb_head;
  logic                    rb_push, rb_pop, rb_full, rb_empty;
  logic [1:0]              rb_count;
  FTk_t                    ld_tok;
  BTk_t                    st_btk;

  // A read issued last cycle already owns a buffer slot.
  assign credit = (rb_count + {1'b0, rd_pend_q}) < 2'd2;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pad_push = 1'b0;
    rd_issue = 1'b0;
    rd_addr  = '0;
    ld_rdy   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.I_Boot) begin
          cnt_d = '0;
          if (BOOT_PAD > 0)      state_d = ST_PAD;
          else if (BOOT_LEN > 0) state_d = ST_BOOT;
          else                   state_d = ST_RUN;
        end
      end
      ST_PAD: begin
        if (credit) begin
          pad_push = 1'b1;
          if (cnt_q == CNT_W'(BOOT_PAD - 1)) begin
            cnt_d = '0;
            if (BOOT_LEN > 0) state_d = ST_BOOT;
            else              state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_BOOT: begin
        if (credit) begin
          rd_issue = 1'b1;
          rd_addr  = WIDTH_EXADDR'(BOOT_BASE) + cnt_q[WIDTH_EXADDR-1:0];
          if (cnt_q == CNT_W'(BOOT_LEN - 1)) begin
            cnt_d   = '0;
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (bus.I_Ld_Req && credit) begin
          ld_rdy   = 1'b1;
          rd_issue = 1'b1;
          rd_addr  = bus.I_Ld_Addr;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stores only get the BRAM port in RUN cycles where no read claims it.
  assign st_nack  = !((state_q == ST_RUN) && !rd_issue);
  assign store_go = bus.I_St_Req & bus.I_St_FTk.v & ~st_nack;

  assign rd_pend_d = rd_issue;
  assign rd_idx_d  = rd_issue ? rd_addr[WIDTH_INDEX-1:0] : '0;

  always_comb begin
    push_entry = '0;
    if (pad_push) begin
      push_entry.a = (cnt_q == '0);
    end else begin
      push_entry.i = rd_idx_q;
      push_entry.d = bus.I_Mem_RData;
    end
  end

  assign rb_push = pad_push | rd_pend_q;
  assign rb_pop  = ~rb_empty & ~bus.I_Ld_BTk.n;

  ext_mem_rbuf u_rbuf (
    .clock     (clock),
    .reset     (reset),
    .push      (rb_push),
    .push_data (push_entry),
    .pop       (rb_pop),
    .head      (rb_head),
    .full      (rb_full),
    .empty     (rb_empty),
    .count     (rb_count)
  );

  always_comb begin
    ld_tok = '0;
    if (!rb_empty) begin
      ld_tok.v = 1'b1;
      ld_tok.a = rb_head.a;
      ld_tok.i = rb_head.i;
      ld_tok.d = rb_head.d;
    end
  end

  always_comb begin
    st_btk   = '0;
    st_btk.n = st_nack;
  end

  assign bus.O_Ld_Rdy    = ld_rdy;
  assign bus.O_Ld_FTk    = ld_tok;
  assign bus.O_St_BTk    = st_btk;
  assign bus.O_Mem_En    = rd_issue | store_go;
  assign bus.O_Mem_We    = store_go;
  assign bus.O_Mem_Addr  = rd_issue ? rd_addr : (store_go ? bus.I_St_Addr : '0);
  assign bus.O_Mem_WData = store_go ? bus.I_St_FTk.d : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  logic unused_sig;
  assign unused_sig = ^{bus.I_St_FTk.a, bus.I_St_FTk.r, bus.I_St_FTk.c, bus.I_St_FTk.i,
                        bus.I_Ld_BTk.t, rb_full};

endmodule

`default_nettype wire
